vram_write_scheduler: RTL and testbench

VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

---
 rtl/vram_write_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_vram_write_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
// Arbitrates fill and blit requests onto the back-buffer VRAM write port and
// manages the front/back buffer swap, which only happens at vblank while idle.
// A fill floods the whole back buffer with one palette index, one 32-bit word
// per cycle. A blit streams a sprite from the sprite store, one pixel per
// cycle, and writes the non-transparent, on-screen pixels as byte-enabled words.
module vram_write_scheduler #(
  parameter int FB_W  = 320,
  parameter int FB_H  = 240,
  parameter int SPR_W = 20,
  parameter int SPR_H = 20
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        fill_req,
  input  logic [7:0]  fill_idx,
  output logic        fill_ack,
  input  logic        blit_req,
  input  logic [8:0]  blit_x,
  input  logic [8:0]  blit_y,
  input  logic [6:0]  blit_id,
  output logic        blit_ack,
  output logic [15:0] spr_addr,
  input  logic [7:0]  spr_data,
  input  logic        swap_req,
  input  logic        vsync_pulse,
  output logic [14:0] vram_addr,
  output logic [31:0] vram_data,
  output logic [3:0]  vram_be,
  output logic        vram_we,
  output logic        frame,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_BLIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic GRANT_FILL = 1'b0;
  localparam logic GRANT_BLIT = 1'b1;

  localparam int WORDS_PER_ROW = FB_W / 4;
  localparam int FILL_WORDS    = (FB_W * FB_H) / 4;
  localparam int SPR_PIXELS    = SPR_W * SPR_H;

  logic [1:0]  state;
  logic        frame_q;
  logic        swap_pend;
  logic        last_grant;
  logic [7:0]  fill_val;
  logic [14:0] fill_cnt;
  logic [9:0]  org_x;
  logic [9:0]  org_y;
  logic [9:0]  col;
  logic [9:0]  row;
  logic [15:0] spr_ptr;

  // Pixel whose sprite address went out last cycle; its data arrives now.
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;

  logic        idle_free;
  logic        grant_fill;
  logic        grant_blit;
  logic        do_swap;
  logic        last_col;
  logic        last_row;
  logic        fill_last;
  logic        pix_on;
  logic [19:0] pix_addr_wide;

  // Grants are only possible in IDLE with no swap pending; on a tie the
  // requester that was not granted last wins. Reset gates the acks so none
  // can appear while the block is held in reset.
  assign idle_free  = RESET_N && (state == ST_IDLE) && !swap_pend;
  assign grant_fill = idle_free && fill_req && (!blit_req || (last_grant == GRANT_BLIT));
  assign grant_blit = idle_free && blit_req && (!fill_req || (last_grant == GRANT_FILL));

  // A swap request in the same cycle as a vsync pulse defers the swap to the
  // following pulse, so the swap is suppressed whenever swap_req is high.
  assign do_swap = vsync_pulse && swap_pend && (state == ST_IDLE) && !swap_req;

  assign last_col  = (col == 10'(SPR_W - 1));
  assign last_row  = (row == 10'(SPR_H - 1));
  assign fill_last = (fill_cnt == 15'(FILL_WORDS - 1));

  // Main sequencer: operand capture on grant, fill counter and sprite scan.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_BLIT;
      fill_val   <= 8'd0;
      fill_cnt   <= 15'd0;
      org_x      <= 10'd0;
      org_y      <= 10'd0;
      col        <= 10'd0;
      row        <= 10'd0;
      spr_ptr    <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fill) begin
            fill_val   <= fill_idx;
            fill_cnt   <= 15'd0;
            last_grant <= GRANT_FILL;
            state      <= ST_FILL;
          end else if (grant_blit) begin
            org_x      <= {1'b0, blit_x};
            org_y      <= {1'b0, blit_y};
            col        <= 10'd0;
            row        <= 10'd0;
            spr_ptr    <= 16'(32'(blit_id) * SPR_PIXELS);
            last_grant <= GRANT_BLIT;
            state      <= ST_BLIT;
          end
        end
        ST_FILL: begin
          if (fill_last) begin
            state <= ST_IDLE;
          end else begin
            fill_cnt <= fill_cnt + 15'd1;
          end
        end
        ST_BLIT: begin
          if (last_col) begin
            col <= 10'd0;
            if (last_row) begin
              state <= ST_DRAIN;
            end else begin
              row     <= row + 10'd1;
              spr_ptr <= spr_ptr + 16'd1;
            end
          end else begin
            col     <= col + 10'd1;
            spr_ptr <= spr_ptr + 16'd1;
          end
        end
        ST_DRAIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Delay the scan coordinates one cycle to line up with the sprite data.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pix_valid <= 1'b0;
      pix_x     <= 10'd0;
      pix_y     <= 10'd0;
    end else begin
      pix_valid <= (state == ST_BLIT);
      pix_x     <= org_x + col;
      pix_y     <= org_y + row;
    end
  end

  // Buffer swap bookkeeping: latch a request, toggle on a vblank seen in IDLE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_q   <= 1'b0;
      swap_pend <= 1'b0;
    end else begin
      if (do_swap) begin
        frame_q   <= ~frame_q;
        swap_pend <= 1'b0;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end

  assign pix_addr_wide = 20'(pix_x >> 2) + (20'(pix_y) * 20'(WORDS_PER_ROW));
  assign pix_on = pix_valid && (spr_data != 8'd0) &&
                  (pix_x < 10'(FB_W)) && (pix_y < 10'(FB_H));

  // VRAM write port mux: fill words while filling, otherwise the pending pixel.
  always_comb begin
    vram_we   = 1'b0;
    vram_addr = 15'd0;
    vram_data = 32'd0;
    vram_be   = 4'd0;
    if (state == ST_FILL) begin
      vram_we   = 1'b1;
      vram_addr = fill_cnt;
      vram_data = {4{fill_val}};
      vram_be   = 4'b1111;
    end else if (pix_valid) begin
      vram_we   = pix_on;
      vram_addr = pix_addr_wide[14:0];
      vram_data = {4{spr_data}};
      vram_be   = 4'b0001 << pix_x[1:0];
    end
  end

  assign fill_ack = grant_fill;
  assign blit_ack = grant_blit;
  assign spr_addr = spr_ptr;
  assign frame    = frame_q;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler
// Directed bench for vram_write_scheduler with hand-computed expectations.
// A small registered sprite store returns data one cycle after its address.
module tb_vram_write_scheduler;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        fill_req = 1'b0;
  logic [7:0]  fill_idx = 8'd0;
  logic        fill_ack;
  logic        blit_req = 1'b0;
  logic [8:0]  blit_x = 9'd0;
  logic [8:0]  blit_y = 9'd0;
  logic [6:0]  blit_id = 7'd0;
  logic        blit_ack;
  logic [15:0] spr_addr;
  logic [7:0]  spr_data = 8'd0;
  logic        swap_req = 1'b0;
  logic        vsync_pulse = 1'b0;
  logic [14:0] vram_addr;
  logic [31:0] vram_data;
  logic [3:0]  vram_be;
  logic        vram_we;
  logic        frame;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] spr_pix = 8'h05;
  int         spr_mode = 0;

  logic [14:0] wr_addr[$];
  logic [3:0]  wr_be[$];
  logic [31:0] wr_data[$];
  int          busy_cyc;
  bit          timed_out;

  vram_write_scheduler dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .fill_req(fill_req), .fill_idx(fill_idx), .fill_ack(fill_ack),
    .blit_req(blit_req), .blit_x(blit_x), .blit_y(blit_y), .blit_id(blit_id),
    .blit_ack(blit_ack), .spr_addr(spr_addr), .spr_data(spr_data),
    .swap_req(swap_req), .vsync_pulse(vsync_pulse),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_be(vram_be),
    .vram_we(vram_we), .frame(frame), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Sprite store: mode 1 makes odd addresses transparent.
  always @(posedge CLK) spr_data <= (spr_mode == 1 && spr_addr[0]) ? 8'h00 : spr_pix;

  // Records writes and busy cycles until busy drops; call at a falling edge.
  task automatic collect(input int limit);
    wr_addr.delete(); wr_be.delete(); wr_data.delete();
    busy_cyc = 0;
    timed_out = 0;
    #1;
    while (busy === 1'b1) begin
      busy_cyc++;
      if (vram_we === 1'b1) begin
        wr_addr.push_back(vram_addr);
        wr_be.push_back(vram_be);
        wr_data.push_back(vram_data);
      end
      if (busy_cyc > limit) begin
        timed_out = 1;
        break;
      end
      @(negedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    fill_req = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame: got %b expected 0", frame); end
    checks++; if (vram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", vram_we); end
    checks++; if (fill_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_fill_ack: got %b expected 0", fill_ack); end
    checks++; if (spr_addr !== 16'd0) begin errors++; $display("[TB] FAIL reset_spr_addr: got %0d expected 0", spr_addr); end
    checks++; if ({vram_addr, vram_data, vram_be} !== 51'd0) begin errors++; $display("[TB] FAIL reset_vram_bus: got %h/%h/%b expected 0", vram_addr, vram_data, vram_be); end
    fill_req = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_fill();
    int bad = 0;
    @(negedge CLK);
    fill_idx = 8'h2A;
    fill_req = 1'b1;
    #1;
    checks++; if (fill_ack !== 1'b1) begin errors++; $display("[TB] FAIL fill_ack: got %b expected 1", fill_ack); end
    @(negedge CLK);
    fill_req = 1'b0;
    collect(20000);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL fill_timeout: got %0d busy cycles expected 19200", busy_cyc); end
    checks++; if (wr_addr.size() != 19200) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 19200", wr_addr.size()); end
    foreach (wr_addr[i])
      if (wr_addr[i] !== 15'(i) || wr_be[i] !== 4'b1111 || wr_data[i] !== 32'h2A2A2A2A) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL fill_words: got %0d bad words expected 0", bad); end
    checks++; if (busy_cyc != 19200) begin errors++; $display("[TB] FAIL fill_busy: got %0d expected 19200", busy_cyc); end
  endtask

  task automatic test_blit_basic();
    int bad = 0;
    spr_mode = 0;
    spr_pix = 8'h05;
    @(negedge CLK);
    blit_x = 9'd3; blit_y = 9'd0; blit_id = 7'd1; blit_req = 1'b1;
    #1;
    checks++; if (blit_ack !== 1'b1) begin errors++; $display("[TB] FAIL blit_ack: got %b expected 1", blit_ack); end
    @(negedge CLK);
    blit_req = 1'b0;
    #1;
    checks++; if (spr_addr !== 16'd400) begin errors++; $display("[TB] FAIL blit_first_spr_addr: got %0d expected 400", spr_addr); end
    collect(1000);
    checks++; if (wr_addr.size() != 400) begin errors++; $display("[TB] FAIL blit_count: got %0d expected 400", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      checks++; if (wr_addr[0] !== 15'd0 || wr_be[0] !== 4'b1000 || wr_data[0] !== 32'h05050505) begin errors++; $display("[TB] FAIL blit_first_write: got %0d/%b/%h expected 0/1000/05050505", wr_addr[0], wr_be[0], wr_data[0]); end
      checks++; if (wr_addr[1] !== 15'd1 || wr_be[1] !== 4'b0001) begin errors++; $display("[TB] FAIL blit_second_write: got %0d/%b expected 1/0001", wr_addr[1], wr_be[1]); end
    end
    foreach (wr_addr[k]) begin
      int x, r;
      x = 3 + (k % 20);
      r = k / 20;
      if (wr_addr[k] !== 15'((x >> 2) + r * 80) || wr_be[k] !== (4'b0001 << (x & 3))) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL blit_pixels: got %0d bad writes expected 0", bad); end
    checks++; if (busy_cyc != 401) begin errors++; $display("[TB] FAIL blit_busy: got %0d expected 401", busy_cyc); end
  endtask

  task automatic test_blit_clip();
    int high = 0;
    int n;
    spr_pix = 8'h11;
    @(negedge CLK);
    blit_x = 9'd310; blit_y = 9'd230; blit_id = 7'd2; blit_req = 1'b1;
    @(negedge CLK);
    blit_req = 1'b0;
    collect(1000);
    n = wr_addr.size();
    checks++; if (n != 100) begin errors++; $display("[TB] FAIL clip_count: got %0d expected 100", n); end
    foreach (wr_addr[k]) if (wr_addr[k] >= 15'd19200) high++;
    checks++; if (high != 0) begin errors++; $display("[TB] FAIL clip_range: got %0d writes past 19199 expected 0", high); end
    if (n > 0) begin
      checks++; if (wr_addr[0] !== 15'd18477 || wr_be[0] !== 4'b0100) begin errors++; $display("[TB] FAIL clip_first: got %0d/%b expected 18477/0100", wr_addr[0], wr_be[0]); end
      checks++; if (wr_addr[n-1] !== 15'd19199 || wr_be[n-1] !== 4'b1000) begin errors++; $display("[TB] FAIL clip_last: got %0d/%b expected 19199/1000", wr_addr[n-1], wr_be[n-1]); end
    end
    checks++; if (busy_cyc != 401) begin errors++; $display("[TB] FAIL clip_busy: got %0d expected 401", busy_cyc); end
  endtask

  task automatic test_transparent();
    int bad = 0;
    spr_mode = 1;
    spr_pix = 8'h33;
    @(negedge CLK);
    blit_x = 9'd0; blit_y = 9'd0; blit_id = 7'd0; blit_req = 1'b1;
    @(negedge CLK);
    blit_req = 1'b0;
    collect(1000);
    checks++; if (wr_addr.size() != 200) begin errors++; $display("[TB] FAIL transp_count: got %0d expected 200", wr_addr.size()); end
    foreach (wr_be[k])
      if ((wr_be[k] !== 4'b0001 && wr_be[k] !== 4'b0100) || wr_data[k] !== 32'h33333333) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL transp_lanes: got %0d bad writes expected 0", bad); end
    spr_mode = 0;
  endtask

  task automatic test_back_to_back();
    int grants[3];
    int n = 0;
    int width_bad = 0;
    int both_bad = 0;
    bit prev = 0;
    @(negedge CLK);
    RESET_N = 1'b0;
    fill_idx = 8'h0F;
    blit_x = 9'd0; blit_y = 9'd0; blit_id = 7'd0;
    fill_req = 1'b1;
    blit_req = 1'b1;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    for (int c = 0; c < 45000 && n < 3; c++) begin
      #1;
      if (fill_ack === 1'b1 && blit_ack === 1'b1) both_bad++;
      if (fill_ack === 1'b1 || blit_ack === 1'b1) begin
        if (prev) width_bad++;
        grants[n] = (fill_ack === 1'b1) ? 0 : 1;
        n++;
        prev = 1;
      end else begin
        prev = 0;
      end
      @(negedge CLK);
    end
    fill_req = 1'b0;
    blit_req = 1'b0;
    #1;
    checks++; if (fill_ack !== 1'b0 || blit_ack !== 1'b0) begin errors++; $display("[TB] FAIL rr_ack_width: got %b%b expected 00", fill_ack, blit_ack); end
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL rr_grant_count: got %0d expected 3", n); end
    if (n == 3) begin
      checks++; if (grants[0] != 0 || grants[1] != 1 || grants[2] != 0) begin errors++; $display("[TB] FAIL rr_order: got %0d%0d%0d expected 010", grants[0], grants[1], grants[2]); end
    end
    checks++; if (width_bad != 0 || both_bad != 0) begin errors++; $display("[TB] FAIL rr_pulses: got %0d long / %0d double expected 0/0", width_bad, both_bad); end
    collect(20000);
  endtask

  task automatic test_swap();
    int early = 0;
    int c = 0;
    @(negedge CLK);
    blit_x = 9'd0; blit_y = 9'd0; blit_id = 7'd0; blit_req = 1'b1;
    @(negedge CLK);
    blit_req = 1'b0;
    swap_req = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
    repeat (50) @(negedge CLK);
    vsync_pulse = 1'b1;
    @(negedge CLK);
    vsync_pulse = 1'b0;
    blit_req = 1'b1;
    #1;
    checks++; if (frame !== 1'b0) begin errors++; $display("[TB] FAIL swap_busy_pulse: got frame %b expected 0", frame); end
    while (busy === 1'b1 && c < 1000) begin
      if (blit_ack === 1'b1) early++;
      @(negedge CLK); #1;
      c++;
    end
    checks++; if (c >= 1000) begin errors++; $display("[TB] FAIL swap_blit_timeout: got %0d cycles expected under 1000", c); end
    repeat (5) begin
      if (blit_ack === 1'b1) early++;
      @(negedge CLK); #1;
    end
    checks++; if (early != 0 || frame !== 1'b0) begin errors++; $display("[TB] FAIL swap_pend_block: got %0d acks frame %b expected 0 acks frame 0", early, frame); end
    @(negedge CLK);
    vsync_pulse = 1'b1;
    #1;
    checks++; if (blit_ack !== 1'b0) begin errors++; $display("[TB] FAIL swap_ack_on_vsync: got %b expected 0", blit_ack); end
    @(negedge CLK);
    vsync_pulse = 1'b0;
    #1;
    checks++; if (frame !== 1'b1) begin errors++; $display("[TB] FAIL swap_toggle: got frame %b expected 1", frame); end
    checks++; if (blit_ack !== 1'b1) begin errors++; $display("[TB] FAIL swap_ack_after: got %b expected 1", blit_ack); end
    @(negedge CLK);
    blit_req = 1'b0;
    collect(1000);
  endtask

  task automatic test_reset_mid_fill();
    int activity = 0;
    @(negedge CLK);
    fill_idx = 8'h77;
    fill_req = 1'b1;
    @(negedge CLK);
    fill_req = 1'b0;
    repeat (100) @(negedge CLK);
    #1;
    checks++; if (vram_we !== 1'b1) begin errors++; $display("[TB] FAIL midfill_active: got we %b expected 1", vram_we); end
    RESET_N = 1'b0;
    #1;
    checks++; if (vram_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midfill_abort: got we %b busy %b expected 0 0", vram_we, busy); end
    checks++; if (frame !== 1'b0) begin errors++; $display("[TB] FAIL midfill_frame: got %b expected 0", frame); end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (50) begin
      @(negedge CLK); #1;
      if (busy !== 1'b0 || vram_we !== 1'b0 || fill_ack !== 1'b0 || blit_ack !== 1'b0) activity++;
    end
    checks++; if (activity != 0) begin errors++; $display("[TB] FAIL midfill_quiet: got %0d active cycles expected 0", activity); end
  endtask

  task automatic test_swap_same_cycle();
    @(negedge CLK);
    swap_req = 1'b1;
    vsync_pulse = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
    vsync_pulse = 1'b0;
    fill_req = 1'b1;
    #1;
    checks++; if (frame !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_frame: got %b expected 0", frame); end
    checks++; if (fill_ack !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_block: got ack %b expected 0", fill_ack); end
    fill_req = 1'b0;
    @(negedge CLK);
    vsync_pulse = 1'b1;
    @(negedge CLK);
    vsync_pulse = 1'b0;
    #1;
    checks++; if (frame !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_next: got frame %b expected 1", frame); end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_fill();
    test_blit_basic();
    test_blit_clip();
    test_transparent();
    test_back_to_back();
    test_swap();
    test_reset_mid_fill();
    test_swap_same_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guards against a hung design.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
